// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage pipeline.
// Resolves load-use, ID jump and EX taken-branch hazards, freezes the
// back end while data memory is busy, and keeps saturating perf counters.
//
// Handshake note: there is no valid/ready pair here. mem_busy is a level
// "not ready" from data memory, sampled every cycle. While it is high the
// pipeline is frozen. The first cycle it is low is a normal RUN-rule cycle.
module pipeline_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int CNT_W    = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] ID_rs,
   input  logic [REG_AW-1:0] ID_rt,
   input  logic              ID_uses_rt,
   input  logic              ID_jump,
   input  logic              EX_MemRead,
   input  logic [REG_AW-1:0] EX_rt,
   input  logic              EX_branch_taken,
   input  logic              mem_busy,
   output logic              pc_write,
   output logic              stall_IF_ID,
   output logic              flush_IF,
   output logic              flush_ID_EX,
   output logic              freeze,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FREEZE = 2'd2
   } state_t;

   localparam logic [15:0] MAX_WAIT_W = 16'(MAX_WAIT);

   state_t             state_q, state_d;
   logic               pend_br_q, pend_br_d;
   logic [15:0]        wait_cnt_q, wait_cnt_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

   logic               run_eval;
   logic               load_use;
   logic               take_br;

   // A cycle out of INIT with memory ready evaluates the RUN hazard rules,
   // including the cycle that leaves FREEZE, so a pending branch lands there.
   assign run_eval = (state_q != ST_INIT) && !mem_busy;
   assign load_use = EX_MemRead && (EX_rt != '0) &&
                     ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
   assign take_br  = EX_branch_taken || pend_br_q;

   // State, pending-branch, wait counter, sticky timeout and counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_INIT;
         pend_br_q   <= 1'b0;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_br_q   <= pend_br_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next-state logic: FSM transitions, branch memory across a freeze, wait timer
   always_comb begin
      state_d    = state_q;
      pend_br_d  = pend_br_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      case (state_q)
         ST_INIT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (mem_busy) begin
               pend_br_d  = EX_branch_taken;
               wait_cnt_d = 16'd1;
               state_d    = ST_FREEZE;
            end else if (take_br) begin
               pend_br_d = 1'b0;
            end
         end
         ST_FREEZE: begin
            if (mem_busy) begin
               pend_br_d = pend_br_q | EX_branch_taken;
               if (wait_cnt_q != 16'hFFFF) begin
                  wait_cnt_d = wait_cnt_q + 16'd1;
               end
               if (wait_cnt_q == MAX_WAIT_W) begin
                  timeout_d = 1'b1;
               end
            end else begin
               wait_cnt_d = '0;
               state_d    = ST_RUN;
               if (take_br) begin
                  pend_br_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Hazard outputs: combinational from state and inputs, same-cycle response
   always_comb begin
      pc_write    = 1'b1;
      stall_IF_ID = 1'b0;
      flush_IF    = 1'b0;
      flush_ID_EX = 1'b0;
      freeze      = 1'b0;
      if (state_q == ST_INIT) begin
         pc_write    = 1'b0;
         flush_IF    = 1'b1;
         flush_ID_EX = 1'b1;
      end else if (mem_busy) begin
         freeze      = 1'b1;
         stall_IF_ID = 1'b1;
         pc_write    = 1'b0;
      end else if (run_eval) begin
         // Branch beats load-use and jump: the stalled instruction is squashed anyway
         if (take_br) begin
            flush_IF    = 1'b1;
            flush_ID_EX = 1'b1;
         end else if (load_use) begin
            stall_IF_ID = 1'b1;
            pc_write    = 1'b0;
            flush_ID_EX = 1'b1;
         end else if (ID_jump) begin
            flush_IF = 1'b1;
         end
      end
   end

   // Saturating perf counters; INIT's power-up flush is not counted
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_IF_ID && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_IF && (state_q != ST_INIT) && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   assign timeout_err = timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MAX_WAIT=4, CNT_W=4 instance).
module tb_pipeline_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [REG_AW-1:0] ID_rs, ID_rt, EX_rt;
   logic              ID_uses_rt, ID_jump, EX_MemRead, EX_branch_taken, mem_busy;
   logic              pc_write, stall_IF_ID, flush_IF, flush_ID_EX, freeze, timeout_err;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   // {pc_write, stall_IF_ID, flush_IF, flush_ID_EX, freeze}
   localparam logic [4:0] HZ_DEF  = 5'b10000;
   localparam logic [4:0] HZ_INIT = 5'b00110;
   localparam logic [4:0] HZ_LU   = 5'b01010;
   localparam logic [4:0] HZ_BR   = 5'b10110;
   localparam logic [4:0] HZ_JMP  = 5'b10100;
   localparam logic [4:0] HZ_FRZ  = 5'b01001;

   logic [4:0] hz;
   assign hz = {pc_write, stall_IF_ID, flush_IF, flush_ID_EX, freeze};

   pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_jump(ID_jump),
      .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .EX_branch_taken(EX_branch_taken),
      .mem_busy(mem_busy),
      .pc_write(pc_write), .stall_IF_ID(stall_IF_ID), .flush_IF(flush_IF),
      .flush_ID_EX(flush_ID_EX), .freeze(freeze), .timeout_err(timeout_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check the hazard vector and the flush/stall exclusivity in the current cycle
   task automatic chk_hz(input string tag, input logic [4:0] exp);
      #1;
      chk(tag, 32'(hz), 32'(exp));
      chk({tag, "_excl"}, 32'(flush_IF & stall_IF_ID), 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      ID_rs = '0; ID_rt = '0; EX_rt = '0;
      ID_uses_rt = 1'b0; ID_jump = 1'b0; EX_MemRead = 1'b0;
      EX_branch_taken = 1'b0; mem_busy = 1'b0;
   endtask

   // Hold reset low two edges, then release into INIT and step to RUN
   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      chk_hz("rst_hz", HZ_INIT);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
      reset = 1'b1;
      chk_hz("init_hz", HZ_INIT);
      tick();
      chk_hz("run_default", HZ_DEF);
   endtask

   initial begin
      idle();
      reset = 1'b0;

      // 1: reset, INIT cycle, RUN defaults
      do_reset();
      chk("run_stall_cnt0", 32'(stall_cnt), 32'd0);
      chk("run_flush_cnt0", 32'(flush_cnt), 32'd0);

      // 2: load-use via rs, via rt, and non-hazards
      EX_MemRead = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
      chk_hz("lu_rs", HZ_LU);
      tick();
      chk("lu_stall_cnt1", 32'(stall_cnt), 32'd1);
      EX_rt = 5'd0; ID_rs = 5'd0;
      chk_hz("lu_r0", HZ_DEF);
      tick();
      EX_rt = 5'd9; ID_rs = 5'd3; ID_rt = 5'd9; ID_uses_rt = 1'b0;
      chk_hz("lu_rt_unused", HZ_DEF);
      tick();
      ID_uses_rt = 1'b1;
      chk_hz("lu_rt_used", HZ_LU);
      tick();
      EX_MemRead = 1'b0;
      chk_hz("no_load", HZ_DEF);
      tick();
      chk("lu_stall_cnt2", 32'(stall_cnt), 32'd2);
      chk("lu_flush_cnt0", 32'(flush_cnt), 32'd0);

      // Jump in ID
      idle();
      ID_jump = 1'b1;
      chk_hz("jump", HZ_JMP);
      tick();
      chk("jump_flush_cnt", 32'(flush_cnt), 32'd1);

      // 3: branch beats load-use and jump
      EX_MemRead = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8; EX_branch_taken = 1'b1;
      chk_hz("br_over_lu", HZ_BR);
      tick();
      chk("br_flush_cnt", 32'(flush_cnt), 32'd2);
      chk("br_stall_cnt", 32'(stall_cnt), 32'd2);

      // 4: freeze 3 cycles with a branch pulse in the 2nd, applied on exit
      idle();
      mem_busy = 1'b1;
      chk_hz("frz_1", HZ_FRZ);
      tick();
      EX_branch_taken = 1'b1;
      chk_hz("frz_2_br", HZ_FRZ);
      tick();
      EX_branch_taken = 1'b0;
      chk_hz("frz_3", HZ_FRZ);
      tick();
      mem_busy = 1'b0;
      chk_hz("frz_exit_br", HZ_BR);
      tick();
      chk_hz("frz_after", HZ_DEF);
      chk("frz_stall_cnt", 32'(stall_cnt), 32'd5);
      chk("frz_flush_cnt", 32'(flush_cnt), 32'd3);
      chk("frz_no_timeout", 32'(timeout_err), 32'd0);

      // 5: timeout with MAX_WAIT=4, sticky until reset
      do_reset();
      mem_busy = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         chk_hz($sformatf("to_frz_%0d", k), HZ_FRZ);
         chk($sformatf("to_flag_%0d", k), 32'(timeout_err), (k >= 6) ? 32'd1 : 32'd0);
         tick();
      end
      mem_busy = 1'b0;
      chk_hz("to_exit", HZ_DEF);
      chk("to_sticky_1", 32'(timeout_err), 32'd1);
      chk("to_stall_cnt", 32'(stall_cnt), 32'd10);
      tick();
      chk("to_sticky_2", 32'(timeout_err), 32'd1);

      // Reset taken mid-freeze returns to INIT
      mem_busy = 1'b1;
      tick();
      chk_hz("mid_frz", HZ_FRZ);
      reset = 1'b0;
      tick();
      chk_hz("mid_rst_init", HZ_INIT);
      chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
      chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
      mem_busy = 1'b0;

      // 6: stall counter saturates at 15
      do_reset();
      EX_MemRead = 1'b1; EX_rt = 5'd4; ID_rs = 5'd4;
      for (int k = 1; k <= 20; k++) begin
         chk($sformatf("sat_cnt_%0d", k), 32'(stall_cnt), (k - 1 > 15) ? 32'd15 : 32'(k - 1));
         tick();
      end
      chk("sat_final", 32'(stall_cnt), 32'd15);
      chk("sat_flush_cnt", 32'(flush_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: observed run still active, expected finish");
      $fatal(1, "time limit");
   end

endmodule
